// File: rtl/pcs_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_pkg
// Purpose  : Shared definitions for the PCS transmit path: scheduler FSM
//            state encodings, the idle byte driven on TXD_ between frames,
//            and 8b/10b code constants shared with the transmitter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcs_tx_pkg;

   // Scheduler states (2-bit encoding)
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Byte presented on TXD_ whenever TX_EN_ is low
   localparam logic [7:0] IDLE_BYTE = 8'h00;

   // Code-group constants shared with the transmitter
   localparam logic [7:0] K27_7 = 8'hFB;  // /S/ start of packet
   localparam logic [7:0] K29_7 = 8'hFD;  // /T/ end of packet
   localparam logic [7:0] K23_7 = 8'hF7;  // /R/ carrier extend
   localparam logic [7:0] K28_5 = 8'hBC;  // comma
   localparam logic [7:0] D21_5 = 8'hB5;  // /C1/ config data
   localparam logic [7:0] D2_2  = 8'h42;  // /C2/ config data
   localparam logic [7:0] D5_6  = 8'hC5;  // /I1/ idle data
   localparam logic [7:0] D16_2 = 8'h50;  // /I2/ idle data

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter, purely combinational. A lone
//            requester always wins; when both request, the pointer picks.
// Ports    : i_req[1:0]   request vector (bit n = source n)
//            i_ptr        preferred source when both request (0 or 1)
//            o_grant[1:0] one-hot winner, all-zero when nothing requests
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
   import pcs_tx_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11) begin
         o_grant = i_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pcs_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_scheduler
// Purpose  : Frame scheduler in front of the PCS transmitter. Arbitrates two
//            byte-stream sources round-robin, forwards one frame at a time to
//            TX_EN_/TXD_ with one cycle of latency, truncates frames longer
//            than MAX_FRAME_LEN and forces IPG_CYCLES idle cycles after every
//            frame. All outputs are registered.
// Ports    : clk_, main_reset_ (async, active high)
//            req0_/req1_, txd0_/txd1_[7:0], last0_/last1_  source inputs
//            gnt0_/gnt1_                                   source grants
//            TX_EN_, TXD_[7:0]                             to transmitter
//            trunc_, abort_                                event pulses
//            frames0_/frames1_[15:0], err_cnt_[7:0]        statistics
// Config   : TX_SCHED_STATS_EN - when defined, adds the statistics ports
//            and counters; otherwise they are absent.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_tx_scheduler
   import pcs_tx_pkg::*;
#(
   parameter int IPG_CYCLES    = 12,
   parameter int MAX_FRAME_LEN = 1518
) (
   input  logic        clk_,
   input  logic        main_reset_,
   input  logic        req0_,
   input  logic        req1_,
   input  logic [7:0]  txd0_,
   input  logic [7:0]  txd1_,
   input  logic        last0_,
   input  logic        last1_,
   output logic        gnt0_,
   output logic        gnt1_,
   output logic        TX_EN_,
   output logic [7:0]  TXD_,
   output logic        trunc_,
   output logic        abort_
`ifdef TX_SCHED_STATS_EN
   ,
   output logic [15:0] frames0_,
   output logic [15:0] frames1_,
   output logic [7:0]  err_cnt_
`endif
);

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        src_q, src_d;              // source owning the current frame
   logic        ptr_q, ptr_d;              // preferred source on contention
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic        trunc_pend_q, trunc_pend_d;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  txd_q, txd_d;
   logic        trunc_q, trunc_d;
   logic        abort_q, abort_d;

   logic [1:0]  w_req;
   logic [1:0]  w_win;
   logic        w_sel_req;
   logic        w_sel_last;
   logic [7:0]  w_sel_txd;
   logic [15:0] w_cnt_inc;

   assign w_req      = {req1_, req0_};
   assign w_sel_req  = src_q ? req1_  : req0_;
   assign w_sel_last = src_q ? last1_ : last0_;
   assign w_sel_txd  = src_q ? txd1_  : txd0_;
   assign w_cnt_inc  = cnt_q + 16'd1;

   rr_arbiter2 u_arb (
      .i_req   (w_req),
      .i_ptr   (ptr_q),
      .o_grant (w_win)
   );

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      src_d        = src_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      trunc_pend_d = trunc_pend_q;
      tx_en_d      = 1'b0;
      txd_d        = IDLE_BYTE;
      trunc_d      = 1'b0;
      abort_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_win != 2'b00) begin
               state_d      = ST_SEND;
               gnt_d        = w_win;
               src_d        = w_win[1];
               cnt_d        = 16'd0;
               trunc_pend_d = 1'b0;
            end
         end

         ST_SEND: begin
            if (gnt_q != 2'b00) begin
               if (!w_sel_req) begin
                  // Source walked away: drop this cycle's byte and close now.
                  abort_d = 1'b1;
                  gnt_d   = 2'b00;
                  state_d = ST_GAP;
                  gap_d   = 8'(IPG_CYCLES);
                  ptr_d   = ~src_q;
               end else begin
                  tx_en_d = 1'b1;
                  txd_d   = w_sel_txd;
                  cnt_d   = w_cnt_inc;
                  // Final byte accepted: release the source now so it stops
                  // streaming; the byte itself is on TXD_ for one more cycle.
                  if (w_sel_last || (w_cnt_inc == 16'(MAX_FRAME_LEN))) begin
                     gnt_d        = 2'b00;
                     trunc_pend_d = ~w_sel_last;
                  end
               end
            end else begin
               // Tail cycle: last byte is on the wire, TX_EN_ falls next.
               state_d      = ST_GAP;
               gap_d        = 8'(IPG_CYCLES);
               ptr_d        = ~src_q;
               trunc_d      = trunc_pend_q;
               trunc_pend_d = 1'b0;
            end
         end

         ST_GAP: begin
            if (gap_q <= 8'd1) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk_ or posedge main_reset_) begin
      if (main_reset_) begin
         state_q      <= ST_IDLE;
         gnt_q        <= 2'b00;
         src_q        <= 1'b0;
         ptr_q        <= 1'b0;
         cnt_q        <= 16'd0;
         gap_q        <= 8'd0;
         trunc_pend_q <= 1'b0;
         tx_en_q      <= 1'b0;
         txd_q        <= IDLE_BYTE;
         trunc_q      <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         src_q        <= src_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         trunc_pend_q <= trunc_pend_d;
         tx_en_q      <= tx_en_d;
         txd_q        <= txd_d;
         trunc_q      <= trunc_d;
         abort_q      <= abort_d;
      end
   end

   assign gnt0_  = gnt_q[0];
   assign gnt1_  = gnt_q[1];
   assign TX_EN_ = tx_en_q;
   assign TXD_   = txd_q;
   assign trunc_ = trunc_q;
   assign abort_ = abort_q;

`ifdef TX_SCHED_STATS_EN
   logic [15:0] frames0_q, frames0_d;
   logic [15:0] frames1_q, frames1_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        w_frame_done;

   // The tail cycle is reached by normal ends and truncations, never aborts.
   assign w_frame_done = (state_q == ST_SEND) && (gnt_q == 2'b00);

   always_comb begin
      frames0_d = frames0_q;
      frames1_d = frames1_q;
      err_cnt_d = err_cnt_q;
      if (w_frame_done) begin
         if (src_q) begin
            frames1_d = frames1_q + 16'd1;
         end else begin
            frames0_d = frames0_q + 16'd1;
         end
      end
      if ((trunc_d || abort_d) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_ or posedge main_reset_) begin
      if (main_reset_) begin
         frames0_q <= 16'd0;
         frames1_q <= 16'd0;
         err_cnt_q <= 8'd0;
      end else begin
         frames0_q <= frames0_d;
         frames1_q <= frames1_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign frames0_ = frames0_q;
   assign frames1_ = frames1_q;
   assign err_cnt_ = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pcs_tx_scheduler
// Purpose  : Self-checking bench for pcs_tx_scheduler. A small source model
//            streams queued bytes while granted; every accepted byte is
//            pushed to a scoreboard and popped when TX_EN_ shows it.
// Config   : TX_SCHED_STATS_EN - also checks the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_scheduler;

   localparam int IPG    = 12;
   localparam int MAXLEN = 8;

   logic        clk_ = 1'b0;
   logic        main_reset_ = 1'b0;
   logic        req0_, req1_, last0_, last1_;
   logic [7:0]  txd0_, txd1_;
   logic        gnt0_, gnt1_, TX_EN_, trunc_, abort_;
   logic [7:0]  TXD_;
`ifdef TX_SCHED_STATS_EN
   logic [15:0] frames0_, frames1_;
   logic [7:0]  err_cnt_;
`endif

   always #5 clk_ = ~clk_;

   pcs_tx_scheduler #(.IPG_CYCLES(IPG), .MAX_FRAME_LEN(MAXLEN)) dut (
      .clk_(clk_), .main_reset_(main_reset_),
      .req0_(req0_), .req1_(req1_), .txd0_(txd0_), .txd1_(txd1_),
      .last0_(last0_), .last1_(last1_), .gnt0_(gnt0_), .gnt1_(gnt1_),
      .TX_EN_(TX_EN_), .TXD_(TXD_), .trunc_(trunc_), .abort_(abort_)
`ifdef TX_SCHED_STATS_EN
      , .frames0_(frames0_), .frames1_(frames1_), .err_cnt_(err_cnt_)
`endif
   );

   typedef struct packed { logic last; logic [7:0] d; } ent_t;

   ent_t       sq0[$];
   ent_t       sq1[$];
   logic [7:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc = 0;
   int         tx_cycles, trunc_seen, abort_seen, trunc_cyc, abort_cyc;
   int         grant_log[$];
   int         rise_q[$];
   int         fall_q[$];
   int         abort_after[2];
   int         sent[2];
   logic       last_seen[2];
   logic       prev_txen = 1'b0;

   function automatic int qsize(input int s);
      if (s == 0) return sq0.size();
      return sq1.size();
   endfunction

   function automatic ent_t qpop(input int s);
      if (s == 0) return sq0.pop_front();
      return sq1.pop_front();
   endfunction

   task automatic qpush(input int s, input logic [7:0] d, input logic last);
      ent_t e;
      e.d = d;
      e.last = last;
      if (s == 0) sq0.push_back(e);
      else        sq1.push_back(e);
   endtask

   task automatic load_frame(input int s, input logic [7:0] base, input int n, input logic with_last);
      for (int i = 0; i < n; i++) qpush(s, base + 8'(i), with_last && (i == n - 1));
   endtask

   task automatic drive_inputs();
      req0_ = (sq0.size() != 0);
      req1_ = (sq1.size() != 0);
      txd0_ = 8'h00; last0_ = 1'b0;
      txd1_ = 8'h00; last1_ = 1'b0;
      if (sq0.size() != 0) begin txd0_ = sq0[0].d; last0_ = sq0[0].last; end
      if (sq1.size() != 0) begin txd1_ = sq1[0].d; last1_ = sq1[0].last; end
   endtask

   task automatic clear_logs();
      tx_cycles = 0; trunc_seen = 0; abort_seen = 0; trunc_cyc = -1; abort_cyc = -1;
      grant_log.delete(); rise_q.delete(); fall_q.delete();
      for (int s = 0; s < 2; s++) begin
         abort_after[s] = 0; sent[s] = 0; last_seen[s] = 1'b0;
      end
   endtask

   // One clock: account for bytes the model handed over, check TXD_ against
   // the scoreboard, log grant/TX_EN_ edges, then drive the next inputs.
   task automatic step();
      logic [1:0] g_b, r_b, g_now;
      logic [7:0] exp_b;
      logic       done;
      ent_t       e;
      g_b = {gnt1_, gnt0_};
      r_b = {req1_, req0_};
      @(posedge clk_);
      #1;
      cyc++;
      for (int s = 0; s < 2; s++) begin
         if (g_b[s] && r_b[s] && qsize(s) != 0) begin
            e = qpop(s);
            exp_q.push_back(e.d);
            last_seen[s] = e.last;
            sent[s]++;
            if (abort_after[s] != 0 && sent[s] == abort_after[s]) begin
               if (s == 0) sq0.delete(); else sq1.delete();
            end
         end
      end
      n_tests++;
      if (TX_EN_) begin
         tx_cycles++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL txd_unexpected: got TXD_=%h with TX_EN_=1, expected no byte", TXD_);
         end else begin
            exp_b = exp_q.pop_front();
            if (TXD_ !== exp_b) begin
               n_fail++;
               $display("FAIL txd_data: got %h expected %h (cycle %0d)", TXD_, exp_b, cyc);
            end
         end
      end else if (TXD_ !== 8'h00) begin
         n_fail++;
         $display("FAIL txd_idle: got %h expected 00 while TX_EN_=0", TXD_);
      end
      if (trunc_) begin trunc_seen++; trunc_cyc = cyc; end
      if (abort_) begin abort_seen++; abort_cyc = cyc; end
      if (prev_txen && !TX_EN_) fall_q.push_back(cyc);
      prev_txen = TX_EN_;
      g_now = {gnt1_, gnt0_};
      for (int s = 0; s < 2; s++) begin
         if (!g_b[s] && g_now[s]) begin
            grant_log.push_back(s);
            rise_q.push_back(cyc);
            last_seen[s] = 1'b0;
         end
         if (g_b[s] && !g_now[s] && !last_seen[s]) begin
            // Cut short: the source discards the rest of that frame.
            done = 1'b0;
            while (!done && qsize(s) != 0) begin
               e = qpop(s);
               done = e.last;
            end
         end
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      main_reset_ = 1'b1;
      sq0.delete(); sq1.delete(); exp_q.delete();
      drive_inputs();
      repeat (2) @(posedge clk_);
      #1;
      main_reset_ = 1'b0;
      prev_txen = 1'b0;
   endtask

   task automatic test_reset();
      sq0.delete(); sq1.delete();
      drive_inputs();
      #2;
      main_reset_ = 1'b1;
      #1;
      n_tests++; if (TX_EN_ !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b expected 0", TX_EN_); end
      n_tests++; if (TXD_ !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h expected 00", TXD_); end
      n_tests++; if ({gnt1_, gnt0_} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", {gnt1_, gnt0_}); end
      n_tests++; if ({trunc_, abort_} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {trunc_, abort_}); end
`ifdef TX_SCHED_STATS_EN
      n_tests++;
      if ({frames0_, frames1_, err_cnt_} !== 40'd0) begin
         n_fail++; $display("FAIL reset_stats: got %h/%h/%h expected 0/0/0", frames0_, frames1_, err_cnt_);
      end
`endif
      repeat (2) @(posedge clk_);
      #1;
      main_reset_ = 1'b0;
      clear_logs();
      repeat (3) step();
      n_tests++; if ({gnt1_, gnt0_} !== 2'b00) begin n_fail++; $display("FAIL idle_gnt: got %b expected 00", {gnt1_, gnt0_}); end
   endtask

   task automatic test_single_frame();
      clear_logs();
      qpush(0, 8'h1B, 1'b0); qpush(0, 8'h1C, 1'b0); qpush(0, 8'h1D, 1'b0); qpush(0, 8'h1E, 1'b1);
      drive_inputs();
      step();
      n_tests++; if (gnt0_ !== 1'b1 || TX_EN_ !== 1'b0) begin n_fail++; $display("FAIL single_grant: got gnt0=%b tx_en=%b expected 1/0", gnt0_, TX_EN_); end
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++; if (TX_EN_ !== 1'b1) begin n_fail++; $display("FAIL single_tx_en: got %b expected 1 at byte %0d", TX_EN_, i); end
      end
      n_tests++; if (gnt0_ !== 1'b0) begin n_fail++; $display("FAIL single_gnt_release: got %b expected 0", gnt0_); end
      step();
      n_tests++; if (TX_EN_ !== 1'b0) begin n_fail++; $display("FAIL single_tx_fall: got %b expected 0", TX_EN_); end
      repeat (IPG + 2) step();
      n_tests++; if (tx_cycles != 4) begin n_fail++; $display("FAIL single_len: got %0d expected 4", tx_cycles); end
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d bytes left expected 0", exp_q.size()); end
   endtask

   task automatic test_contention(input logic rst_first, input int first);
      int exp_order[3];
      if (rst_first) do_reset();
      clear_logs();
      exp_order[0] = first;
      exp_order[1] = (first == 0) ? 1 : 0;
      exp_order[2] = 0;
      load_frame(0, 8'h20, 3, 1'b1);
      load_frame(0, 8'h40, 3, 1'b1);
      load_frame(1, 8'h30, 3, 1'b1);
      drive_inputs();
      repeat (80) step();
      n_tests++;
      if (grant_log.size() != 3) begin
         n_fail++; $display("FAIL contention_grants: got %0d grants expected 3", grant_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (grant_log[i] != exp_order[i]) begin
               n_fail++; $display("FAIL contention_order: grant %0d got src%0d expected src%0d", i, grant_log[i], exp_order[i]);
            end
         end
      end
      n_tests++; if (tx_cycles != 9) begin n_fail++; $display("FAIL contention_len: got %0d expected 9", tx_cycles); end
      n_tests++;
      if (rise_q.size() != 3 || fall_q.size() != 3) begin
         n_fail++; $display("FAIL contention_edges: got %0d rises %0d falls expected 3/3", rise_q.size(), fall_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (rise_q[i+1] - fall_q[i] != IPG + 1) begin
               n_fail++; $display("FAIL contention_gap: got %0d cycles expected %0d", rise_q[i+1] - fall_q[i], IPG + 1);
            end
         end
      end
   endtask

   task automatic test_truncation();
      clear_logs();
      load_frame(1, 8'h60, 20, 1'b0);
      drive_inputs();
      repeat (40) step();
      n_tests++; if (tx_cycles != MAXLEN) begin n_fail++; $display("FAIL trunc_len: got %0d expected %0d", tx_cycles, MAXLEN); end
      n_tests++; if (trunc_seen != 1) begin n_fail++; $display("FAIL trunc_pulse: got %0d pulses expected 1", trunc_seen); end
      n_tests++;
      if (fall_q.size() != 1 || trunc_cyc != fall_q[0]) begin
         n_fail++; $display("FAIL trunc_timing: got trunc at %0d expected at TX_EN_ fall", trunc_cyc);
      end
      n_tests++; if (abort_seen != 0) begin n_fail++; $display("FAIL trunc_abort: got %0d expected 0", abort_seen); end
      n_tests++; if (gnt1_ !== 1'b0) begin n_fail++; $display("FAIL trunc_gnt: got %b expected 0", gnt1_); end
   endtask

   task automatic test_abort();
      clear_logs();
      load_frame(0, 8'hA0, 6, 1'b1);
      abort_after[0] = 3;
      drive_inputs();
      repeat (40) step();
      n_tests++; if (tx_cycles != 3) begin n_fail++; $display("FAIL abort_len: got %0d expected 3", tx_cycles); end
      n_tests++; if (abort_seen != 1) begin n_fail++; $display("FAIL abort_pulse: got %0d pulses expected 1", abort_seen); end
      n_tests++;
      if (fall_q.size() != 1 || abort_cyc != fall_q[0]) begin
         n_fail++; $display("FAIL abort_timing: got abort at %0d expected at TX_EN_ fall", abort_cyc);
      end
      n_tests++; if (trunc_seen != 0) begin n_fail++; $display("FAIL abort_trunc: got %0d expected 0", trunc_seen); end
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_drain: got %0d bytes left expected 0", exp_q.size()); end
   endtask

   task automatic test_last_at_max();
      clear_logs();
      load_frame(0, 8'hC0, MAXLEN, 1'b1);
      drive_inputs();
      repeat (30) step();
      n_tests++; if (tx_cycles != MAXLEN) begin n_fail++; $display("FAIL maxlast_len: got %0d expected %0d", tx_cycles, MAXLEN); end
      n_tests++; if (trunc_seen != 0) begin n_fail++; $display("FAIL maxlast_trunc: got %0d expected 0", trunc_seen); end
   endtask

   task automatic test_abort_gap();
      clear_logs();
      load_frame(0, 8'hD0, 4, 1'b1);
      abort_after[0] = 2;
      drive_inputs();
      step();
      load_frame(1, 8'hE0, 2, 1'b1);
      drive_inputs();
      repeat (40) step();
      n_tests++;
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
         n_fail++; $display("FAIL abortgap_order: got %0d grants expected src0 then src1", grant_log.size());
      end
      n_tests++; if (tx_cycles != 4) begin n_fail++; $display("FAIL abortgap_len: got %0d expected 4", tx_cycles); end
      n_tests++;
      if (rise_q.size() != 2 || fall_q.size() < 1 || rise_q[1] - fall_q[0] != IPG + 1) begin
         n_fail++; $display("FAIL abortgap_gap: got %0d rises expected gap of %0d cycles after abort", rise_q.size(), IPG + 1);
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_logs();
      load_frame(0, 8'h70, 6, 1'b1);
      drive_inputs();
      repeat (4) step();
      n_tests++; if (TX_EN_ !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got tx_en=%b expected 1", TX_EN_); end
      #2;
      main_reset_ = 1'b1;
      #1;
      n_tests++;
      if (TX_EN_ !== 1'b0 || TXD_ !== 8'h00 || {gnt1_, gnt0_} !== 2'b00 || abort_ !== 1'b0) begin
         n_fail++; $display("FAIL midrst_async: got tx_en=%b txd=%h gnt=%b abort=%b expected 0/00/00/0", TX_EN_, TXD_, {gnt1_, gnt0_}, abort_);
      end
`ifdef TX_SCHED_STATS_EN
      n_tests++;
      if ({frames0_, frames1_, err_cnt_} !== 40'd0) begin
         n_fail++; $display("FAIL midrst_stats: got %h/%h/%h expected 0/0/0", frames0_, frames1_, err_cnt_);
      end
`endif
      sq0.delete(); sq1.delete(); exp_q.delete();
      clear_logs();
      load_frame(0, 8'h80, 3, 1'b1);
      load_frame(1, 8'h90, 3, 1'b1);
      drive_inputs();
      repeat (2) @(posedge clk_);
      #1;
      main_reset_ = 1'b0;
      prev_txen = 1'b0;
      repeat (60) step();
      n_tests++;
      if (grant_log.size() == 0 || grant_log[0] != 0) begin
         n_fail++; $display("FAIL midrst_first: got %0d grants, first not src0, expected src0 first", grant_log.size());
      end
      n_tests++; if (abort_seen != 0) begin n_fail++; $display("FAIL midrst_abort: got %0d expected 0", abort_seen); end
      n_tests++; if (tx_cycles != 6) begin n_fail++; $display("FAIL midrst_len: got %0d expected 6", tx_cycles); end
   endtask

`ifdef TX_SCHED_STATS_EN
   task automatic test_stats();
      do_reset();
      test_single_frame();
      test_contention(1'b0, 1);
      test_truncation();
      test_abort();
      n_tests++; if (frames0_ !== 16'd3) begin n_fail++; $display("FAIL stats_frames0: got %0d expected 3", frames0_); end
      n_tests++; if (frames1_ !== 16'd2) begin n_fail++; $display("FAIL stats_frames1: got %0d expected 2", frames1_); end
      n_tests++; if (err_cnt_ !== 8'd2) begin n_fail++; $display("FAIL stats_err: got %0d expected 2", err_cnt_); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_contention(1'b1, 0);
      test_truncation();
      test_abort();
      test_last_at_max();
      test_reset_mid_frame();
      test_abort_gap();
`ifdef TX_SCHED_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
